// File: rtl/tog_sync_pkg.sv
// Shared types for the multi-channel toggle-synchronizer receiver.
// Holds the offer FSM encoding and the minimum synchronizer depth.
package tog_sync_pkg;

   localparam int STAGES_MIN = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage

// File: rtl/tog_sync_rx_mc_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous reset.
// The input is only ever sampled by the first flop of the chain.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] s;

   always_ff @(posedge clk) begin
      if (rst) begin
         s <= '0;
      end else begin
         s <= {s[STAGES-2:0], d};
      end
   end

   assign q = s[STAGES-1];

endmodule

// File: rtl/tog_sync_rx_mc.sv
// Multi-channel toggle-handshake receiver: per-channel hold registers
// drained one word at a time through a round-robin valid/ready port.
module tog_sync_rx_mc
   import tog_sync_pkg::*;
#(
   parameter int N      = 8,
   parameter int CH     = 4,
   parameter int STAGES = 2,
   localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clkB,
   input  logic          rst,
   input  logic [CH-1:0] req_tog,
   input  logic [CH*N-1:0] data_in,
   output logic [CH-1:0] ack_tog,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_ch,
   output logic [N-1:0]  out_data,
   output logic [CH-1:0] err,
   input  logic          err_clr
);

   localparam int SD = (STAGES < STAGES_MIN) ? STAGES_MIN : STAGES;

   logic [CH-1:0] s_q, dly, edg;
   logic [CH-1:0] pend, pend_n;
   logic [CH-1:0] err_q, err_set;
   logic [CH-1:0] ack_q, ack_n;
   logic [CH-1:0] cap;
   logic [N-1:0]  hold [CH];
   state_t        state, state_n;
   logic [CW-1:0] grant, grant_n;
   logic [CW-1:0] ptr, ptr_n;
   logic [CW-1:0] pick;
   logic          found;
   logic          xfer;
   int            idx;

   for (genvar c = 0; c < CH; c++) begin : g_sync
      sync_ff #(.STAGES(SD)) u_sync (
         .clk (clkB),
         .rst (rst),
         .d   (req_tog[c]),
         .q   (s_q[c])
      );
   end

   assign edg  = s_q ^ dly;
   assign xfer = (state == OFFER) && out_ready;

   // Round-robin search starting at ptr.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < CH; i++) begin
         idx = (int'(ptr) + i) % CH;
         if (!found && pend[idx]) begin
            pick  = CW'(idx);
            found = 1'b1;
         end
      end
   end

   // A new edge while still pending is an overrun; data is only
   // replaced when the old word leaves in that same cycle.
   always_comb begin
      cap     = '0;
      err_set = '0;
      pend_n  = pend;
      ack_n   = ack_q;
      for (int c = 0; c < CH; c++) begin
         cap[c]     = edg[c] && (!pend[c] || (xfer && grant == CW'(c)));
         err_set[c] = edg[c] && pend[c];
         if (edg[c]) begin
            pend_n[c] = 1'b1;
         end else if (xfer && grant == CW'(c)) begin
            pend_n[c] = 1'b0;
         end
         if (xfer && grant == CW'(c)) begin
            ack_n[c] = ~ack_q[c];
         end
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      unique case (state)
         IDLE: begin
            if (|pend) begin
               grant_n = pick;
               state_n = OFFER;
            end
         end
         OFFER: begin
            if (out_ready) begin
               state_n = IDLE;
               ptr_n   = (int'(grant) == CH - 1) ? '0 : grant + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clkB) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
         dly   <= '0;
         pend  <= '0;
         err_q <= '0;
         ack_q <= '0;
         for (int c = 0; c < CH; c++) begin
            hold[c] <= '0;
         end
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr   <= ptr_n;
         dly   <= s_q;
         pend  <= pend_n;
         err_q <= (err_clr ? '0 : err_q) | err_set;
         ack_q <= ack_n;
         for (int c = 0; c < CH; c++) begin
            if (cap[c]) begin
               hold[c] <= data_in[c*N +: N];
            end
         end
      end
   end

   assign out_valid = (state == OFFER);
   assign out_ch    = grant;
   assign out_data  = hold[grant];
   assign ack_tog   = ack_q;
   assign err       = err_q;

endmodule

// File: doc/tog_sync_rx_mc.md
TOG_SYNC_RX_MC -- requirements
Module: tog_sync_rx_mc

Interface
REQ-001 SHALL have parameter N, default 8, data width per channel.
REQ-002 SHALL have parameter CH, default 4, channel count, range 1..16.
REQ-003 SHALL have parameter STAGES, default 2, synchronizer depth, minimum 2.
REQ-004 SHALL have port clkB input 1, the single receive-domain clock.
REQ-005 SHALL have port rst input 1, synchronous active-high reset.
REQ-006 SHALL have port req_tog input CH, per-channel request toggle from the source domain (asynchronous).
REQ-007 SHALL have port data_in input CH*N, channel c data at bits [c*N +: N], held stable by the source from toggle until matching ack.
REQ-008 SHALL have port ack_tog output CH, per-channel acknowledge toggle to the source domain.
REQ-009 SHALL have port out_valid output 1, delivered word available.
REQ-010 SHALL have port out_ready input 1, consumer accepts.
REQ-011 SHALL have port out_ch output $clog2(CH) (min 1), channel index of the delivered word.
REQ-012 SHALL have port out_data output N, the delivered word.
REQ-013 SHALL have port err output CH, sticky per-channel overrun flag.
REQ-014 SHALL have port err_clr input 1, single-cycle clear of all err bits.

Function
REQ-015 SHALL pass each req_tog bit through STAGES flops; nothing else SHALL sample req_tog directly.
REQ-016 SHALL detect an edge when the last sync stage differs from its one-cycle-delayed copy; edge-to-capture latency is STAGES+1 clkB edges.
REQ-017 On edge with pend[c]=0, SHALL capture data_in channel c into hold[c] and set pend[c] in the same cycle.
REQ-018 On edge with pend[c]=1 and channel c not transferring that cycle, SHALL set err[c] and drop the new data (hold[c] unchanged).
REQ-019 On edge with pend[c]=1 and channel c transferring that cycle, SHALL set err[c], capture new data, and keep pend[c]=1.
REQ-020 SHALL use FSM IDLE/OFFER: IDLE with any pend -> latch grant via round-robin from ptr, go OFFER; IDLE with none -> stay.
REQ-021 In OFFER, out_valid SHALL be 1, with out_ch=grant and out_data=hold[grant] held constant until transfer.
REQ-022 Transfer (OFFER and out_ready) SHALL clear pend[grant], invert ack_tog[grant], set ptr=(grant+1) mod CH, and return to IDLE.
REQ-023 Sustained throughput SHALL be at most one word per two cycles; out_valid SHALL be 0 in IDLE.
REQ-024 err_clr SHALL clear err in the same cycle; a set event in that cycle SHALL win.
REQ-025 out_data SHALL be registered or driven from registered hold/grant only; no path from data_in to out_data.

Reset
REQ-026 On rst, sync chains, delay copies, pend, hold, err, ack_tog and ptr SHALL be 0, FSM=IDLE, out_valid=0, out_ch=0, out_data=0.
REQ-027 Reset mid-OFFER SHALL abandon the word with no ack toggle; source and receiver SHALL be reset together, with req_tog=0 at release.

Structure
REQ-028 Package tog_sync_pkg SHALL hold the FSM state enum and constant STAGES_MIN=2.
REQ-029 A sub-module sync_ff (parameter STAGES, 1-bit, synchronous reset) SHALL be instanced once per channel.

Verification
REQ-030 CH=4, N=8: toggle req_tog[1] with data 'hAA, out_ready=1 -> out_valid at edge+STAGES+2, out_ch=1, out_data='hAA, ack_tog[1] flips on transfer.
REQ-031 Toggle channels 0, 2 and 3 in the same cycle, out_ready=1 -> delivery order 0, 2, 3, then ptr=0; each ack flips exactly once.
REQ-032 out_ready=0 for 20 cycles while offering ch 2 ('h55) -> out_ch/out_data stable and no ack flip until out_ready=1.
REQ-033 Toggle req_tog[0] twice without waiting for ack ('h11 then 'h22) -> err[0]=1, delivered 'h11 once; err_clr -> err[0]=0.
REQ-034 Assert rst during OFFER -> next cycle all outputs 0, ack_tog unchanged from reset value 0, no delivery after release.
